// File: rtl/issue_fifo.sv
// Circular-buffer issue queue between id_stage and instr_reorder, with head and one-entry lookahead.
// Optional macro ISSUE_FIFO_BYPASS_EN: an entry arriving at an empty queue is presented in the same cycle.
module issue_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [31:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  entry_t                   issue_entry_i,
    input  logic                     issue_entry_valid_i,
    input  logic                     is_ctrl_flow_i,
    output logic                     issue_instr_ack_o,
    output entry_t                   issue_entry_o,
    output logic                     issue_entry_valid_o,
    output logic                     is_ctrl_flow_o,
    input  logic                     issue_instr_ack_i,
    output entry_t                   next_entry_o,
    output logic                     next_valid_o,
    output logic [$clog2(DEPTH):0]   fill_level_o
);

    // Handshake: a transfer happens on a rising edge where valid and ack are both high.
    // Upstream ack depends only on registered occupancy, flush and reset, never on valid.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);

    entry_t           mem_q [DEPTH];
    logic [DEPTH-1:0] ctrl_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stored_valid;
    logic             bypass;
    logic             push;
    logic             pop;

    assign rd_next      = rd_ptr_q + 1'b1;
    assign stored_valid = rst_ni && !flush_i && (count_q != '0);

    // Reset gates ack combinationally so it reads 0 for the whole reset window.
    assign issue_instr_ack_o = rst_ni && !flush_i && (count_q < FULL_C);
    assign next_valid_o      = rst_ni && !flush_i && (count_q >= TWO_C);
    assign next_entry_o      = mem_q[rd_next];
    assign fill_level_o      = count_q;

`ifdef ISSUE_FIFO_BYPASS_EN
    assign bypass              = rst_ni && !flush_i && (count_q == '0) && issue_entry_valid_i;
    assign issue_entry_valid_o = stored_valid || bypass;
    assign issue_entry_o       = bypass ? issue_entry_i  : mem_q[rd_ptr_q];
    assign is_ctrl_flow_o      = bypass ? is_ctrl_flow_i : ctrl_q[rd_ptr_q];
`else
    assign bypass              = 1'b0;
    assign issue_entry_valid_o = stored_valid;
    assign issue_entry_o       = mem_q[rd_ptr_q];
    assign is_ctrl_flow_o      = ctrl_q[rd_ptr_q];
`endif

    // A bypassed entry consumed in its arrival cycle never touches storage.
    assign push = issue_entry_valid_i && issue_instr_ack_o && !(bypass && issue_instr_ack_i);
    assign pop  = stored_valid && issue_instr_ack_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_next;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; its contents only matter behind a valid flag.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q]  <= issue_entry_i;
            ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
        end
    end

endmodule

// File: tb/tb_issue_fifo.sv
// Self-checking bench for issue_fifo (DEPTH=4): directed table, corner sequences, random traffic vs a queue model.
// Honours ISSUE_FIFO_BYPASS_EN when the design is built with it.
module tb_issue_fifo;

  localparam int unsigned DEPTH = 4;
`ifdef ISSUE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] entry_i;
  logic        valid_i;
  logic        ctrl_i;
  logic        ack_o;
  logic [31:0] entry_o;
  logic        valid_o;
  logic        ctrl_o;
  logic        ack_i;
  logic [31:0] next_o;
  logic        next_valid_o;
  logic [2:0]  fill_o;

  issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .issue_entry_i      (entry_i),
    .issue_entry_valid_i(valid_i),
    .is_ctrl_flow_i     (ctrl_i),
    .issue_instr_ack_o  (ack_o),
    .issue_entry_o      (entry_o),
    .issue_entry_valid_o(valid_o),
    .is_ctrl_flow_o     (ctrl_o),
    .issue_instr_ack_i  (ack_i),
    .next_entry_o       (next_o),
    .next_valid_o       (next_valid_o),
    .fill_level_o       (fill_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {ctrl, entry}
  logic [32:0] exp_q[$];
  logic        m_pop, m_push, m_flush, m_byp;
  logic [32:0] m_head;
  logic [31:0] got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [31:0] e, input logic c,
                       input logic a, input logic f);
    int n;
    logic e_ack, e_val;
    @(negedge clk_i);
    valid_i = v; entry_i = e; ctrl_i = c; ack_i = a; flush_i = f;
    #1;
    n     = exp_q.size();
    m_byp = BYP && (n == 0) && v && !f;
    e_ack = (n < DEPTH) && !f;
    e_val = ((n > 0) && !f) || m_byp;
    chk("ack_o", ack_o, e_ack);
    chk("valid_o", valid_o, e_val);
    chk("next_valid_o", next_valid_o, (n >= 2) && !f);
    chk("fill_level_o", fill_o, n);
    m_head = '0;
    if (e_val) begin
      m_head = m_byp ? {c, e} : exp_q[0];
      chk("head_entry", entry_o, m_head[31:0]);
      chk("head_ctrl", ctrl_o, m_head[32]);
    end
    if ((n >= 2) && !f) chk("next_entry", next_o, exp_q[1][31:0]);
    m_pop   = e_val && a;
    m_push  = v && e_ack && !(m_byp && a);
    m_flush = f;
    if (m_pop) got_q.push_back(m_head[31:0]);
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (m_flush) exp_q.delete();
    else begin
      if (m_pop && (exp_q.size() > 0)) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({ctrl_i, entry_i});
    end
  endtask

  task automatic step(input logic v, input logic [31:0] e, input logic c,
                      input logic a, input logic f);
    apply(v, e, c, a, f);
    advance();
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] in_entry;
    logic        in_ctrl;
    logic        in_ack;
    logic        in_flush;
    logic        e_ack;
    logic        e_valid;
    logic [31:0] e_head;
    logic        e_ctrl;
    logic        e_nv;
    logic [31:0] e_next;
    logic [2:0]  e_fill;
  } vec_t;

  localparam logic [31:0] A = 32'hA1, B = 32'hB2, C = 32'hC3, D = 32'hD4, E = 32'hE5, F = 32'hF6;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0};
    tbl[1]  = '{1'b1, A,     1'b0, 1'b0, 1'b0, 1'b1, BYP,  A,     1'b0, 1'b0, 32'h0, 3'd0};
    tbl[2]  = '{1'b1, B,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, A,     1'b0, 1'b0, 32'h0, 3'd1};
    tbl[3]  = '{1'b1, C,     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A,     1'b0, 1'b1, B,     3'd2};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A,     1'b0, 1'b1, B,     3'd3};
    tbl[5]  = '{1'b1, D,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, A,     1'b0, 1'b1, B,     3'd3};
    tbl[6]  = '{1'b1, E,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, A,     1'b0, 1'b1, B,     3'd4};
    tbl[7]  = '{1'b1, E,     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A,     1'b0, 1'b1, B,     3'd4};
    tbl[8]  = '{1'b1, E,     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, B,     1'b1, 1'b1, C,     3'd3};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B,     1'b1, 1'b1, C,     3'd4};
    tbl[10] = '{1'b1, F,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd4};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0};
    tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0};

    // Clock/reset
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; entry_i = '0; ctrl_i = 1'b0; ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ack_o", ack_o, 1'b0);
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_next_valid_o", next_valid_o, 1'b0);
    chk("rst_fill", fill_o, 3'd0);
    rst_ni = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].in_valid, tbl[i].in_entry, tbl[i].in_ctrl, tbl[i].in_ack, tbl[i].in_flush);
      chk($sformatf("tbl%0d_ack", i), ack_o, tbl[i].e_ack);
      chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].e_valid);
      chk($sformatf("tbl%0d_nv", i), next_valid_o, tbl[i].e_nv);
      chk($sformatf("tbl%0d_fill", i), fill_o, tbl[i].e_fill);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_head", i), entry_o, tbl[i].e_head);
        chk($sformatf("tbl%0d_ctrl", i), ctrl_o, tbl[i].e_ctrl);
      end
      if (tbl[i].e_nv) chk($sformatf("tbl%0d_next", i), next_o, tbl[i].e_next);
      advance();
    end

    // Flush with three entries held and a push offered
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + i, i[0], 1'b0, 1'b0);
    apply(1'b1, 32'h2FF, 1'b1, 1'b0, 1'b1);
    chk("flush_valid_same_cycle", valid_o, 1'b0);
    chk("flush_ack_same_cycle", ack_o, 1'b0);
    advance();
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("post_flush_fill", fill_o, 3'd0);
      chk("post_flush_valid", valid_o, 1'b0);
      advance();
    end
    chk("flushed_entry_issued", got_q.size(), 0);

    // Continuous push+pop across pointer wrap
    got_q.delete();
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      apply(1'b1, 32'h100 + i, 1'b0, 1'b1, 1'b0);
      chk("wrap_fill_const", fill_o, 3'd1);
      advance();
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("wrap_pop_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk($sformatf("wrap_order%0d", i), got_q[i], 32'h100 + i);

    // Empty queue, push X with downstream ack
    apply(1'b1, 32'h5A5A, 1'b1, 1'b1, 1'b0);
    chk("x_valid_same_cycle", valid_o, BYP);
    advance();
`ifdef ISSUE_FIFO_BYPASS_EN
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("x_bypass_fill", fill_o, 3'd0);
    advance();
`else
    apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("x_late_valid", valid_o, 1'b1);
    chk("x_late_head", entry_o, 32'h5A5A);
    chk("x_late_fill", fill_o, 3'd1);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("x_drained_fill", fill_o, 3'd0);
    advance();
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0; ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_fill", fill_o, 3'd0);
    chk("async_rst_valid", valid_o, 1'b0);
    chk("async_rst_ack", ack_o, 1'b0);
    chk("async_rst_nv", next_valid_o, 1'b0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + i, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_fifo.md
ISSUE_FIFO -- requirements
Module: issue_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of queued scoreboard entries; SHALL be a power of two, 2..16.
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  synchronous pipeline flush.
REQ-005 issue_entry_i  input  $bits(ariane_pkg::scoreboard_entry_t)  decoded entry from id_stage.
REQ-006 issue_entry_valid_i  input  1  issue_entry_i is valid.
REQ-007 is_ctrl_flow_i  input  1  entry is a control-flow instruction.
REQ-008 issue_instr_ack_o  output  1  entry accepted this cycle.
REQ-009 issue_entry_o  output  $bits(scoreboard_entry_t)  head entry toward instr_reorder.
REQ-010 issue_entry_valid_o  output  1  head entry valid.
REQ-011 is_ctrl_flow_o  output  1  head control-flow flag.
REQ-012 issue_instr_ack_i  input  1  downstream consumed head.
REQ-013 next_entry_o  output  $bits(scoreboard_entry_t)  entry behind head (lookahead).
REQ-014 next_valid_o  output  1  next_entry_o valid.
REQ-015 fill_level_o  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

Function
REQ-016 Storage SHALL be a circular buffer: read pointer, write pointer, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; separate counter for occupancy.
REQ-017 issue_instr_ack_o SHALL be 1 iff count < DEPTH and flush_i = 0; combinational path from issue_entry_valid_i to issue_instr_ack_o SHALL NOT exist.
REQ-018 Push: issue_entry_valid_i & issue_instr_ack_o SHALL write {entry, is_ctrl_flow} at write pointer and advance it; valid_i=0 SHALL write nothing.
REQ-019 Pop: issue_entry_valid_o & issue_instr_ack_i SHALL advance read pointer; issue_instr_ack_i with valid_o=0 SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; allowed at any count < DEPTH.
REQ-021 Full (count = DEPTH): push refused, pop allowed; the slot freed becomes acceptable next cycle only.
REQ-022 Empty: issue_entry_valid_o = 0 (unless REQ-031 bypass), issue_entry_o = stale slot content, don't-care.
REQ-023 issue_entry_o/is_ctrl_flow_o SHALL come from read pointer slot; next_entry_o from slot read pointer+1 (mod DEPTH); next_valid_o = count >= 2.
REQ-024 Latency without bypass: entry pushed in cycle N SHALL be presented with valid_o = 1 in cycle N+1 if queue was empty.
REQ-025 Order SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-026 flush_i SHALL force issue_entry_valid_o = 0, next_valid_o = 0, issue_instr_ack_o = 0 in the same cycle, and reset pointers and count to 0 next cycle; a pop or push in the flush cycle SHALL be discarded.
REQ-027 fill_level_o SHALL equal registered count, updated the cycle after each push/pop.

Reset
REQ-028 On rst_ni = 0: pointers = 0, count = 0, issue_entry_valid_o = 0, next_valid_o = 0, fill_level_o = 0, issue_instr_ack_o = 0 while asserted.
REQ-029 Storage array need not be reset; outputs driven from it are don't-care while valid is 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Configuration
REQ-031 Macro ISSUE_FIFO_BYPASS_EN defined: when count = 0 and issue_entry_valid_i = 1 and flush_i = 0, outputs SHALL mirror inputs combinationally (valid_o = 1); if issue_instr_ack_i = 1 that cycle the entry SHALL NOT be written (count stays 0), else it is written normally.
REQ-032 Macro undefined: no input-to-output combinational path; REQ-024 latency applies.

Verification
REQ-033 Reset, then push A,B,C on 3 cycles, ack_i = 0 -> fill_level_o = 3, head = A, next = B, next_valid_o = 1.
REQ-034 DEPTH = 4, push 5 entries back-to-back, ack_i = 0 -> issue_instr_ack_o = 0 on 5th cycle, fill_level_o = 4, 5th entry retried.
REQ-035 Full queue, push and ack_i same cycle -> push refused, fill_level_o = 3; next cycle push accepted, fill_level_o = 4.
REQ-036 Continuous push+pop for 10 entries (pointer wrap) -> output order matches input 0..9, fill_level_o constant.
REQ-037 Queue holding 3 entries, flush_i = 1 with push valid -> valid_o = 0 same cycle, fill_level_o = 0 next cycle, pushed entry never issued.
REQ-038 Empty queue, push X with ack_i = 1 -> with ISSUE_FIFO_BYPASS_EN: valid_o = 1, issue_entry_o = X same cycle, fill_level_o stays 0; without: X appears next cycle, fill_level_o = 1 then 0.
